vector_history_buffer: RTL and testbench
========================================

VECTOR_HISTORY_BUFFER -- requirements
Module: vector_history_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one element.
REQ-002 SHALL have parameter NUM_ELEMENTS, default 50, elements per stored vector.
REQ-003 SHALL have parameter DATA_DEPTH, default 10, vectors held (legal range >= 2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wr_en  input  1  push din as newest vector.
REQ-007 SHALL have port din  input  DATA_WIDTH x NUM_ELEMENTS unpacked array  write vector.
REQ-008 SHALL have port rd_en  input  1  read one vector at the current cursor.
REQ-009 SHALL have port rd_mode  input  1  0 = newest-to-oldest replay, 1 = forward loop.
REQ-010 SHALL have port clr  input  1  synchronous logical flush.
REQ-011 SHALL have port dout  output  DATA_WIDTH x NUM_ELEMENTS unpacked array  read vector, registered.
REQ-012 SHALL have port dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-013 SHALL have port rd_last  output  1  asserted with dout_valid when the returned vector is the oldest held.
REQ-014 SHALL have port count  output  $clog2(DATA_DEPTH+1)  number of valid vectors.
REQ-015 SHALL have ports full/empty  output  1 each  count==DATA_DEPTH / count==0, combinational from count.
REQ-016 SHALL have port rd_err  output  1  one-cycle pulse for a read with count==0.
REQ-017 SHALL have port collision  output  1  one-cycle pulse when wr_en and rd_en are high together.

Function
REQ-018 SHALL store vectors in a DATA_DEPTH-entry ring; wr_ptr is the next write slot and wraps DATA_DEPTH-1 -> 0.
REQ-019 SHALL track the read cursor as age (0 = newest, count-1 = oldest); physical address = (wr_ptr-1-age) mod DATA_DEPTH, computed without out-of-range intermediates.
REQ-020 SHALL, on wr_en, write din to wr_ptr, advance wr_ptr, set age to 0, and increment count saturating at DATA_DEPTH.
REQ-021 SHALL, on wr_en while full, overwrite the oldest vector, leaving count at DATA_DEPTH.
REQ-022 SHALL, on rd_en with count>0 and no wr_en, register the addressed vector onto dout and pulse dout_valid exactly one cycle later (latency 1).
REQ-023 SHALL, in rd_mode 0, advance age to min(age+1, count-1) after each read, repeating the oldest vector once reached.
REQ-024 SHALL, in rd_mode 1, move age toward newer (age-1) after each read, wrapping from age 0 to age count-1, visiting only valid vectors.
REQ-025 SHALL drive rd_last high in the dout_valid cycle iff the returned vector had age count-1.
REQ-026 SHALL hold dout at its last value whenever dout_valid is low.
REQ-027 SHALL, on rd_en with count==0, leave dout unchanged, keep dout_valid low, and pulse rd_err one cycle later.
REQ-028 SHALL, on simultaneous wr_en and rd_en, perform the write only, drop the read, and pulse collision one cycle later.
REQ-029 SHALL, on clr, set count, wr_ptr and age to 0 without clearing storage; clr has priority over wr_en and rd_en in the same cycle.
REQ-030 SHALL allow rd_mode to change between any two reads, the cursor continuing from its current age.
REQ-031 SHALL never let reads modify count, wr_ptr or stored data.

Reset
REQ-032 SHALL, while rst is high at a clk edge, set wr_ptr=0, age=0, count=0, dout all zero, dout_valid=0, rd_last=0, rd_err=0, collision=0; rst overrides clr, wr_en and rd_en.
REQ-033 SHALL not reset storage contents; reads are refused via empty until new writes occur.
REQ-034 SHALL, on reset mid-read, suppress the pending dout_valid/rd_err pulse of that read.

Verification (DATA_DEPTH=4, NUM_ELEMENTS=2; vector k has both elements = k)
REQ-035 SHALL cover: write 1,2,3, then five rd_mode=0 reads -> dout 3,2,1,1,1; rd_last on the 3rd, 4th and 5th reads; count=3.
REQ-036 SHALL cover: write 1..6 (overflow) -> count=4, full=1; rd_mode=1 reads from age 0 -> 6,3,4,5,6; rd_last on the read returning 3.
REQ-037 SHALL cover: after reset, rd_en -> rd_err pulse, dout_valid=0, dout=0, empty=1.
REQ-038 SHALL cover: write 1,2, then wr_en=rd_en=1 with din=7 -> collision pulse, no dout_valid, count=3; next rd_mode=0 read -> 7.
REQ-039 SHALL cover: write 1,2,3, clr together with wr_en -> count=0, empty=1; subsequent read -> rd_err.
REQ-040 SHALL cover: rst asserted the cycle after rd_en -> no dout_valid pulse, all outputs at reset values.

Source files
------------

// File: rtl/vector_history_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vector_history_buffer
// Description : Ring buffer of DATA_DEPTH vectors with age-based replay reads.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_history_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 50,
    parameter int DATA_DEPTH   = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [DATA_WIDTH-1:0]             din [NUM_ELEMENTS],
    input  logic                              rd_en,
    input  logic                              rd_mode,
    input  logic                              clr,
    output logic [DATA_WIDTH-1:0]             dout [NUM_ELEMENTS],
    output logic                              dout_valid,
    output logic                              rd_last,
    output logic [$clog2(DATA_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              empty,
    output logic                              rd_err,
    output logic                              collision
);

    localparam int c_PTR_W = $clog2(DATA_DEPTH);
    localparam int c_CNT_W = $clog2(DATA_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DATA_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_SLOT = c_PTR_W'(DATA_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH][NUM_ELEMENTS];
    logic [DATA_WIDTH-1:0] r_dout [NUM_ELEMENTS];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_age;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_dout_valid;
    logic                  r_rd_last;
    logic                  r_rd_err;
    logic                  r_collision;

    logic [c_PTR_W-1:0]    w_newest;
    logic [c_PTR_W-1:0]    w_rd_addr;
    logic [c_CNT_W-1:0]    w_count_m1;
    logic [c_PTR_W-1:0]    w_oldest_age;
    logic                  w_at_oldest;
    logic                  w_do_write;
    logic                  w_do_read;

    assign w_newest     = (r_wr_ptr == '0) ? c_LAST_SLOT : r_wr_ptr - c_PTR_W'(1);
    // Wrap by adding the complement instead of subtracting below zero.
    assign w_rd_addr    = (r_age <= w_newest) ? (w_newest - r_age)
                        : (w_newest + (c_LAST_SLOT - r_age) + c_PTR_W'(1));
    assign w_count_m1   = r_count - c_CNT_W'(1);
    assign w_oldest_age = w_count_m1[c_PTR_W-1:0];
    assign w_at_oldest  = (r_age == w_oldest_age);
    assign w_do_write   = wr_en && !clr && !rst;
    assign w_do_read    = rd_en && !wr_en && !clr && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int e = 0; e < NUM_ELEMENTS; e++) begin
                r_mem[r_wr_ptr][e] <= din[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_age        <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_err     <= 1'b0;
            r_collision  <= 1'b0;
            for (int e = 0; e < NUM_ELEMENTS; e++) begin
                r_dout[e] <= '0;
            end
        end else begin
            r_dout_valid <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_err     <= 1'b0;
            r_collision  <= 1'b0;
            if (clr) begin
                r_wr_ptr <= '0;
                r_age    <= '0;
                r_count  <= '0;
            end else if (wr_en) begin
                r_wr_ptr    <= (r_wr_ptr == c_LAST_SLOT) ? '0 : r_wr_ptr + c_PTR_W'(1);
                r_age       <= '0;
                r_count     <= (r_count == c_DEPTH) ? r_count : r_count + c_CNT_W'(1);
                r_collision <= rd_en;
            end else if (rd_en && (r_count == '0)) begin
                r_rd_err <= 1'b1;
            end else if (w_do_read) begin
                for (int e = 0; e < NUM_ELEMENTS; e++) begin
                    r_dout[e] <= r_mem[w_rd_addr][e];
                end
                r_dout_valid <= 1'b1;
                r_rd_last    <= w_at_oldest;
                if (!rd_mode) begin
                    r_age <= w_at_oldest ? r_age : r_age + c_PTR_W'(1);
                end else begin
                    r_age <= (r_age == '0) ? w_oldest_age : r_age - c_PTR_W'(1);
                end
            end
        end
    end

    // Pulses are masked while rst is high so a read caught by reset never reports.
    assign dout_valid = r_dout_valid & ~rst;
    assign rd_last    = r_rd_last    & ~rst;
    assign rd_err     = r_rd_err     & ~rst;
    assign collision  = r_collision  & ~rst;
    assign dout       = r_dout;
    assign count      = r_count;
    assign full       = (r_count == c_DEPTH);
    assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_vector_history_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_history_buffer
// Description : Scoreboard bench for vector_history_buffer (depth 4, 2 elements).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_history_buffer;

    localparam int DW = 8;
    localparam int NE = 2;
    localparam int DD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din [NE];
    logic          rd_en = 1'b0;
    logic          rd_mode = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] dout [NE];
    logic          dout_valid;
    logic          rd_last;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          rd_err;
    logic          collision;

    vector_history_buffer #(
        .DATA_WIDTH   (DW),
        .NUM_ELEMENTS (NE),
        .DATA_DEPTH   (DD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .rd_mode    (rd_mode),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .rd_last    (rd_last),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .rd_err     (rd_err),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    // kind: 0 = data vector, 1 = read error, 2 = collision
    typedef struct {
        int kind;
        int val;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_dout = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_dout = 0;
    endtask

    task automatic wr(input int k);
        wr_en = 1'b1;
        din[0] = DW'(k);
        din[1] = DW'(k);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input bit mode, input int val, input bit last);
        exp_t e;
        e.kind = 0;
        e.val  = val;
        e.last = last;
        exp_dout = val;
        q.push_back(e);
        rd_en = 1'b1;
        rd_mode = mode;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rd_expect_err();
        exp_t e;
        e.kind = 1;
        e.val  = exp_dout;
        e.last = 1'b0;
        q.push_back(e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain", q.size(), 0);
    endtask

    // Monitor: pops one expectation per observed DUT event.
    always @(negedge clk) begin
        if (dout_valid || rd_err || collision) begin
            int act_kind;
            exp_t e;
            act_kind = dout_valid ? 0 : (rd_err ? 1 : 2);
            chk("single_event", int'(dout_valid) + int'(rd_err) + int'(collision), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d expected none at %0t", act_kind, $time);
            end else begin
                e = q.pop_front();
                chk("event_kind", act_kind, e.kind);
                chk("dout0", int'(dout[0]), e.val);
                chk("dout1", int'(dout[1]), e.val);
                chk("rd_last", int'(rd_last), int'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        din[0] = '0;
        din[1] = '0;
        do_reset();

        // Empty after reset: read refused
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        rd_expect_err();
        drain();
        chk("err_empty", int'(empty), 1);

        // Newest-to-oldest replay
        wr(1); wr(2); wr(3);
        rd(1'b0, 3, 1'b0);
        rd(1'b0, 2, 1'b0);
        rd(1'b0, 1, 1'b1);
        rd(1'b0, 1, 1'b1);
        rd(1'b0, 1, 1'b1);
        drain();
        chk("replay_count", int'(count), 3);

        // Overflow then forward loop
        do_reset();
        for (int k = 1; k <= 6; k++) wr(k);
        chk("ovf_count", int'(count), 4);
        chk("ovf_full", int'(full), 1);
        rd(1'b1, 6, 1'b0);
        rd(1'b1, 3, 1'b1);
        rd(1'b1, 4, 1'b0);
        rd(1'b1, 5, 1'b0);
        rd(1'b1, 6, 1'b0);
        drain();
        chk("loop_count", int'(count), 4);

        // Collision: write wins, read dropped
        do_reset();
        wr(1); wr(2);
        begin
            exp_t e;
            e.kind = 2;
            e.val  = exp_dout;
            e.last = 1'b0;
            q.push_back(e);
        end
        rd_en = 1'b1;
        wr(7);
        rd_en = 1'b0;
        drain();
        chk("coll_count", int'(count), 3);
        rd(1'b0, 7, 1'b0);
        drain();

        // Clear beats a simultaneous write
        wr(1); wr(2); wr(3);
        clr = 1'b1;
        wr(9);
        clr = 1'b0;
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        rd_expect_err();
        drain();

        // Reset in the cycle after a read suppresses its pulse
        wr(1); wr(2);
        rd_en = 1'b1;
        rd_mode = 1'b0;
        tick();
        rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_dout = 0;
        chk("rr_count", int'(count), 0);
        chk("rr_empty", int'(empty), 1);
        chk("rr_dout0", int'(dout[0]), 0);
        chk("rr_dout1", int'(dout[1]), 0);
        chk("rr_dout_valid", int'(dout_valid), 0);
        chk("rr_rd_last", int'(rd_last), 0);
        chk("rr_rd_err", int'(rd_err), 0);
        chk("rr_collision", int'(collision), 0);
        tick();
        tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
